fluid_board_soc_onchip_mem_copy_master: RTL and testbench
=========================================================

FLUID_BOARD_SOC_ONCHIP_MEM_COPY_MASTER -- requirements
Module: fluid_board_soc_onchip_mem_copy_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word address width of the shared on-chip RAM port.
REQ-002 SHALL have parameter DATA_W, default 16, RAM data width; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports csr_address  in  2, csr_chipselect  in  1, csr_write  in  1, csr_read  in  1, csr_writedata  in  16, csr_readdata  out  16: zero-wait-state control slave.
REQ-006 SHALL have ports mem_address  out  ADDR_W, mem_chipselect  out  1, mem_write  out  1, mem_byteenable  out  DATA_W/8, mem_writedata  out  DATA_W, mem_clken  out  1, mem_readdata  in  DATA_W: master onto the second port of the dual-port RAM.
REQ-007 SHALL have port irq  out  1  level interrupt, high while DONE and IRQ_EN are both 1.

Function
REQ-008 CSR map: 0 CTRL/STATUS, 1 SRC, 2 DST, 3 LEN (word count); csr_readdata combinational from csr_address when csr_chipselect & csr_read, else 0.
REQ-009 CTRL bits: [0] START write-1 pulse, reads 0; [1] BUSY read-only; [2] DONE read, write-1-to-clear; [3] IRQ_EN read/write; [4] ABORT write-1 pulse, reads 0.
REQ-010 SRC and DST SHALL hold ADDR_W bits (upper bits read 0); writes to SRC/DST/LEN while BUSY SHALL be ignored.
REQ-011 FSM states IDLE, RD, CAP, WR; reset state IDLE.
REQ-012 IDLE: START with LEN!=0 -> RD next cycle, BUSY=1, DONE cleared, working counters loaded from SRC/DST/LEN; START with LEN==0 -> stay IDLE, DONE=1 next cycle.
REQ-013 RD: mem_chipselect=1, mem_write=0, mem_address=src pointer; -> CAP unconditionally.
REQ-014 CAP: mem_readdata is valid (RAM read latency exactly 1 cycle); latch into data register; -> WR.
REQ-015 WR: mem_chipselect=1, mem_write=1, mem_byteenable all ones, mem_address=dst pointer, mem_writedata=latched data; pointers increment, count decrements; -> RD if count after decrement !=0, else IDLE with BUSY=0, DONE=1.
REQ-016 Each word SHALL take exactly 3 cycles; LEN=N completes 3N cycles after the START write cycle.
REQ-017 Pointers SHALL wrap modulo 2^ADDR_W (0x7FFF+1 -> 0x0000).
REQ-018 ABORT while BUSY -> IDLE at next edge from any state, BUSY=0, DONE not set, no further bus cycles; ABORT while idle has no effect.
REQ-019 START while BUSY SHALL be ignored; START and ABORT written together: ABORT wins.
REQ-020 Write-1 to DONE in the same cycle the FSM sets DONE: set wins.
REQ-021 mem_chipselect and mem_write SHALL be 0 in IDLE and CAP; mem_clken SHALL be constant 1.
REQ-022 SRC/DST/LEN are not modified by a transfer; overlapping regions copy forward word by word without hazard protection.

Reset
REQ-023 reset_n low SHALL force, asynchronously: state IDLE, SRC=DST=LEN=0, BUSY=DONE=IRQ_EN=0, counters/data register 0, irq=0, mem_chipselect=mem_write=0, mem_address=0, mem_writedata=0.
REQ-024 Reset asserted mid-transfer SHALL abandon the transfer; no write cycle is issued after reset_n deasserts until a new START.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, CSR offsets, and CTRL bit indices.
REQ-026 One sub-module, fluid_board_soc_copy_csr, SHALL implement the register file and DONE/IRQ logic; the top holds the FSM and datapath.

Verification
REQ-027 Bench SHALL use a behavioural 32768x16 RAM model with 1-cycle read latency and byteenable.
REQ-028 SRC=0x0100, DST=0x0200, LEN=4, RAM[0x100..0x103]=0xA0A0,0x1234,0xFFFF,0x0001, START -> DST words match, BUSY high 12 cycles, DONE=1, irq=1 with IRQ_EN=1.
REQ-029 SRC=0x7FFE, DST=0x0010, LEN=3 -> reads at 0x7FFE,0x7FFF,0x0000; writes at 0x0010..0x0012.
REQ-030 LEN=0, START -> no mem_chipselect ever, DONE=1 one cycle later.
REQ-031 LEN=8, ABORT after 7 cycles -> exactly 2 words written, BUSY=0, DONE=0; SRC write during BUSY leaves SRC unchanged.
REQ-032 reset_n low in WR state of word 2 -> all outputs at reset values immediately; write DONE=1 after a completed transfer -> DONE=0, irq=0.

Source files
------------

// File: rtl/fluid_board_soc_onchip_mem_copy_master_pkg.sv
// Shared definitions for the on-chip memory copy master: FSM states, CSR map, CTRL bits.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fluid_board_soc_onchip_mem_copy_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } copy_state_e;

    // CSR word offsets
    localparam logic [1:0] CSR_CTRL = 2'd0;
    localparam logic [1:0] CSR_SRC  = 2'd1;
    localparam logic [1:0] CSR_DST  = 2'd2;
    localparam logic [1:0] CSR_LEN  = 2'd3;

    // CTRL/STATUS bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_BUSY   = 1;
    localparam int CTRL_DONE   = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_ABORT  = 4;

endpackage

// File: rtl/fluid_board_soc_copy_csr.sv
// Register file for the copy master: SRC/DST/LEN, IRQ_EN, DONE and the level interrupt.
// Latency: readback is combinational; register writes take effect at the next clk edge.
// Backpressure: none, zero-wait-state slave; SRC/DST/LEN writes are dropped while busy.
// Ports: csr_* slave bus; busy/done_set/done_clr from the FSM; start_req/abort_req
//        are single-cycle decodes of CTRL writes; src/dst/len feed the datapath; irq out.
module fluid_board_soc_copy_csr
    import fluid_board_soc_onchip_mem_copy_master_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_chipselect,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [15:0]       csr_writedata,
    output logic [15:0]       csr_readdata,
    input  logic              busy,
    input  logic              done_set,
    input  logic              done_clr,
    output logic              start_req,
    output logic              abort_req,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [15:0]       len,
    output logic              irq
);

    logic irq_en;
    logic done;
    logic bus_wr;
    logic ctrl_wr;
    logic done_w1c;

    assign bus_wr    = csr_chipselect & csr_write;
    assign ctrl_wr   = bus_wr & (csr_address == CSR_CTRL);
    assign start_req = ctrl_wr & csr_writedata[CTRL_START];
    assign abort_req = ctrl_wr & csr_writedata[CTRL_ABORT];
    assign done_w1c  = ctrl_wr & csr_writedata[CTRL_DONE];
    assign irq       = done & irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            irq_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            // Transfer parameters are frozen while a copy is running.
            if (bus_wr && !busy) begin
                case (csr_address)
                    CSR_SRC: src <= csr_writedata[ADDR_W-1:0];
                    CSR_DST: dst <= csr_writedata[ADDR_W-1:0];
                    CSR_LEN: len <= csr_writedata;
                    default: ;
                endcase
            end
            if (ctrl_wr) begin
                irq_en <= csr_writedata[CTRL_IRQ_EN];
            end
            // A completion in the same cycle as a write-1-to-clear keeps DONE set.
            if (done_set) begin
                done <= 1'b1;
            end else if (done_clr || done_w1c) begin
                done <= 1'b0;
            end
        end
    end

    always_comb begin
        csr_readdata = '0;
        if (csr_chipselect && csr_read) begin
            case (csr_address)
                CSR_CTRL: begin
                    csr_readdata[CTRL_BUSY]   = busy;
                    csr_readdata[CTRL_DONE]   = done;
                    csr_readdata[CTRL_IRQ_EN] = irq_en;
                end
                CSR_SRC: csr_readdata[ADDR_W-1:0] = src;
                CSR_DST: csr_readdata[ADDR_W-1:0] = dst;
                CSR_LEN: csr_readdata = len;
                default: csr_readdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/fluid_board_soc_onchip_mem_copy_master.sv
// Word-by-word copy master on the second port of a dual-port RAM (read, capture, write).
// Latency: 3 cycles per word; LEN=N finishes 3N cycles after the START write.
// Backpressure: none; the RAM is assumed always ready with a fixed 1-cycle read latency.
// Ports: clk/reset_n; csr_* control slave (CTRL, SRC, DST, LEN); mem_* RAM master port;
//        irq is high while DONE and IRQ_EN are both set.
module fluid_board_soc_onchip_mem_copy_master
    import fluid_board_soc_onchip_mem_copy_master_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            csr_address,
    input  logic                  csr_chipselect,
    input  logic                  csr_write,
    input  logic                  csr_read,
    input  logic [15:0]           csr_writedata,
    output logic [15:0]           csr_readdata,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  irq
);

    copy_state_e        state;
    copy_state_e        state_nxt;
    logic [ADDR_W-1:0]  src_ptr;
    logic [ADDR_W-1:0]  dst_ptr;
    logic [15:0]        count;
    logic [15:0]        count_dec;
    logic [DATA_W-1:0]  data_q;

    logic               busy;
    logic               start_req;
    logic               abort_req;
    logic               done_set;
    logic               done_clr;
    logic               load;
    logic               advance;
    logic               latch;
    logic [ADDR_W-1:0]  src;
    logic [ADDR_W-1:0]  dst;
    logic [15:0]        len;

    assign busy      = (state != ST_IDLE);
    assign count_dec = count - 16'd1;
    assign mem_clken = 1'b1;

    fluid_board_soc_copy_csr #(
        .ADDR_W (ADDR_W)
    ) u_csr (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write      (csr_write),
        .csr_read       (csr_read),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .busy           (busy),
        .done_set       (done_set),
        .done_clr       (done_clr),
        .start_req      (start_req),
        .abort_req      (abort_req),
        .src            (src),
        .dst            (dst),
        .len            (len),
        .irq            (irq)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load           = 1'b0;
        advance        = 1'b0;
        latch          = 1'b0;
        done_set       = 1'b0;
        done_clr       = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;

        case (state)
            ST_IDLE: begin
                // START alongside ABORT is dropped; a zero-length copy completes at once.
                if (start_req && !abort_req) begin
                    if (len != 16'd0) begin
                        state_nxt = ST_RD;
                        load      = 1'b1;
                        done_clr  = 1'b1;
                    end else begin
                        done_set  = 1'b1;
                    end
                end
            end
            ST_RD: begin
                mem_chipselect = 1'b1;
                mem_address    = src_ptr;
                mem_byteenable = '1;
                state_nxt      = ST_CAP;
            end
            ST_CAP: begin
                latch     = 1'b1;
                state_nxt = ST_WR;
            end
            ST_WR: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_byteenable = '1;
                mem_address    = dst_ptr;
                mem_writedata  = data_q;
                advance        = 1'b1;
                if (count_dec != 16'd0) begin
                    state_nxt = ST_RD;
                end else begin
                    state_nxt = ST_IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort overrides everything, including a completion on the last word.
        if (abort_req && busy) begin
            state_nxt = ST_IDLE;
            done_set  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            data_q  <= '0;
        end else begin
            if (load) begin
                src_ptr <= src;
                dst_ptr <= dst;
                count   <= len;
            end else if (advance) begin
                // Pointers wrap naturally at the RAM size.
                src_ptr <= src_ptr + 1'b1;
                dst_ptr <= dst_ptr + 1'b1;
                count   <= count_dec;
            end
            if (latch) begin
                data_q <= mem_readdata;
            end
        end
    end

endmodule

// File: tb/tb_fluid_board_soc_onchip_mem_copy_master.sv
// Bench for the copy master: CSR vector table plus multi-cycle copy, wrap, abort and reset cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_fluid_board_soc_onchip_mem_copy_master;
    import fluid_board_soc_onchip_mem_copy_master_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  csr_address;
    logic        csr_chipselect;
    logic        csr_write;
    logic        csr_read;
    logic [15:0] csr_writedata;
    logic [15:0] csr_readdata;
    logic [14:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [1:0]  mem_byteenable;
    logic [15:0] mem_writedata;
    logic        mem_clken;
    logic [15:0] mem_readdata;
    logic        irq;

    fluid_board_soc_onchip_mem_copy_master #(.ADDR_W(15), .DATA_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write      (csr_write),
        .csr_read       (csr_read),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 32768x16 RAM, 1-cycle read latency, byte enables; bd_* is a preload backdoor.
    logic [15:0] ram [0:32767];
    logic [15:0] ram_q;
    logic        bd_we;
    logic [14:0] bd_addr;
    logic [15:0] bd_dat;
    assign mem_readdata = ram_q;

    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_dat;
        end else if (mem_chipselect && mem_write) begin
            if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
            if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
        end
        if (mem_chipselect && !mem_write) ram_q <= ram[mem_address];
    end

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] dat;
    } wr_t;

    typedef struct {
        logic        do_wr;
        logic [1:0]  waddr;
        logic [15:0] wdata;
        logic [1:0]  raddr;
        logic [15:0] exp;
    } vec_t;

    wr_t         exp_wr_q[$];
    logic [14:0] exp_rd_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observe this cycle's bus activity against the scoreboard, then advance one clock.
    task automatic tick();
        wr_t         e;
        logic [14:0] ra;
        if (mem_write && !mem_chipselect) chk("write_without_cs", 32'(mem_write), 32'd0);
        if (mem_chipselect && mem_write) begin
            if (exp_wr_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         mem_address, mem_writedata);
            end else begin
                e = exp_wr_q.pop_front();
                chk("wr_addr", 32'(mem_address), 32'(e.addr));
                chk("wr_data", 32'(mem_writedata), 32'(e.dat));
                chk("wr_be", 32'(mem_byteenable), 32'h3);
            end
        end else if (mem_chipselect) begin
            if (exp_rd_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_read: got addr 0x%0h, expected no read", mem_address);
            end else begin
                ra = exp_rd_q.pop_front();
                chk("rd_addr", 32'(mem_address), 32'(ra));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [15:0] d);
        csr_address    = a;
        csr_writedata  = d;
        csr_chipselect = 1'b1;
        csr_write      = 1'b1;
        tick();
        csr_chipselect = 1'b0;
        csr_write      = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [15:0] d);
        csr_address    = a;
        csr_chipselect = 1'b1;
        csr_read       = 1'b1;
        #1;
        d              = csr_readdata;
        csr_chipselect = 1'b0;
        csr_read       = 1'b0;
    endtask

    task automatic preload(input logic [14:0] a, input logic [15:0] d);
        bd_addr = a;
        bd_dat  = d;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    // Count cycles with BUSY set, bounded by max_cyc.
    task automatic wait_idle(input int max_cyc, output int n);
        logic [15:0] r;
        bit          going;
        n     = 0;
        going = 1'b1;
        while (going) begin
            csr_rd(CSR_CTRL, r);
            if (!r[1]) begin
                going = 1'b0;
            end else if (n >= max_cyc) begin
                compared++;
                mismatched++;
                $display("FAIL busy_timeout: got busy after %0d cycles, expected idle", n);
                going = 1'b0;
            end else begin
                n++;
                tick();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [10];
        logic [15:0] rd;
        logic [15:0] a_data [4];
        int          busy_n;

        a_data[0] = 16'hA0A0; a_data[1] = 16'h1234; a_data[2] = 16'hFFFF; a_data[3] = 16'h0001;

        vecs[0] = '{1'b0, CSR_CTRL, 16'h0000, CSR_CTRL, 16'h0000};
        vecs[1] = '{1'b0, CSR_SRC,  16'h0000, CSR_SRC,  16'h0000};
        vecs[2] = '{1'b0, CSR_DST,  16'h0000, CSR_DST,  16'h0000};
        vecs[3] = '{1'b0, CSR_LEN,  16'h0000, CSR_LEN,  16'h0000};
        vecs[4] = '{1'b1, CSR_SRC,  16'hFFFF, CSR_SRC,  16'h7FFF};
        vecs[5] = '{1'b1, CSR_DST,  16'h8ABC, CSR_DST,  16'h0ABC};
        vecs[6] = '{1'b1, CSR_LEN,  16'h0005, CSR_LEN,  16'h0005};
        vecs[7] = '{1'b1, CSR_CTRL, 16'h0008, CSR_CTRL, 16'h0008};
        vecs[8] = '{1'b1, CSR_CTRL, 16'h0011, CSR_CTRL, 16'h0000};
        vecs[9] = '{1'b1, CSR_CTRL, 16'h0004, CSR_CTRL, 16'h0000};

        reset_n        = 1'b0;
        csr_address    = '0;
        csr_chipselect = 1'b0;
        csr_write      = 1'b0;
        csr_read       = 1'b0;
        csr_writedata  = '0;
        bd_we          = 1'b0;
        bd_addr        = '0;
        bd_dat         = '0;
        #2;
        chk("rst_cs",    32'(mem_chipselect), 32'd0);
        chk("rst_write", 32'(mem_write),      32'd0);
        chk("rst_addr",  32'(mem_address),    32'd0);
        chk("rst_wdata", 32'(mem_writedata),  32'd0);
        chk("rst_irq",   32'(irq),            32'd0);
        chk("clken",     32'(mem_clken),      32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // CSR table: reset values, address masking, abort-beats-start, idle w1c
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) csr_wr(vecs[i].waddr, vecs[i].wdata);
            csr_rd(vecs[i].raddr, rd);
            chk($sformatf("csr_vec%0d", i), 32'(rd), 32'(vecs[i].exp));
        end
        csr_address    = CSR_LEN;
        csr_chipselect = 1'b1;
        #1;
        chk("rd_gated_no_read", 32'(csr_readdata), 32'd0);
        csr_chipselect = 1'b0;

        // Basic 4-word copy with interrupt
        for (int i = 0; i < 4; i++) begin
            preload(15'h0100 + 15'(i), a_data[i]);
            exp_rd_q.push_back(15'h0100 + 15'(i));
            exp_wr_q.push_back('{15'h0200 + 15'(i), a_data[i]});
        end
        csr_wr(CSR_SRC, 16'h0100);
        csr_wr(CSR_DST, 16'h0200);
        csr_wr(CSR_LEN, 16'h0004);
        csr_wr(CSR_CTRL, 16'h0009);
        wait_idle(40, busy_n);
        chk("a_busy_cycles", 32'(busy_n), 32'd12);
        csr_rd(CSR_CTRL, rd);
        chk("a_ctrl_done", 32'(rd), 32'h000C);
        chk("a_irq", 32'(irq), 32'd1);
        for (int i = 0; i < 4; i++) chk($sformatf("a_ram%0d", i), 32'(ram[15'h0200 + 15'(i)]), 32'(a_data[i]));
        chk("a_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        chk("a_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        csr_rd(CSR_SRC, rd);
        chk("a_src_kept", 32'(rd), 32'h0100);
        csr_rd(CSR_LEN, rd);
        chk("a_len_kept", 32'(rd), 32'h0004);
        csr_wr(CSR_CTRL, 16'h000C);
        csr_rd(CSR_CTRL, rd);
        chk("a_done_w1c", 32'(rd), 32'h0008);
        chk("a_irq_clr", 32'(irq), 32'd0);

        // Source pointer wraps at the top of the RAM; mid-transfer START ignored
        preload(15'h7FFE, 16'h1111);
        preload(15'h7FFF, 16'h2222);
        preload(15'h0000, 16'h3333);
        exp_rd_q.push_back(15'h7FFE); exp_rd_q.push_back(15'h7FFF); exp_rd_q.push_back(15'h0000);
        exp_wr_q.push_back('{15'h0010, 16'h1111});
        exp_wr_q.push_back('{15'h0011, 16'h2222});
        exp_wr_q.push_back('{15'h0012, 16'h3333});
        csr_wr(CSR_SRC, 16'h7FFE);
        csr_wr(CSR_DST, 16'h0010);
        csr_wr(CSR_LEN, 16'h0003);
        csr_wr(CSR_CTRL, 16'h0001);
        tick();
        tick();
        csr_wr(CSR_CTRL, 16'h0001);
        wait_idle(40, busy_n);
        chk("b_busy_after_restart", 32'(busy_n), 32'd6);
        csr_rd(CSR_CTRL, rd);
        chk("b_ctrl_done", 32'(rd), 32'h0004);
        chk("b_ram12", 32'(ram[15'h0012]), 32'h3333);
        chk("b_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        chk("b_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);

        // Zero length: DONE next cycle, no bus cycles
        csr_wr(CSR_CTRL, 16'h0004);
        csr_wr(CSR_LEN, 16'h0000);
        csr_wr(CSR_CTRL, 16'h0001);
        csr_rd(CSR_CTRL, rd);
        chk("c_len0_done", 32'(rd), 32'h0004);
        repeat (6) tick();
        // DONE set and write-1-to-clear in the same cycle: set wins
        csr_wr(CSR_CTRL, 16'h0004);
        csr_rd(CSR_CTRL, rd);
        chk("c_done_cleared", 32'(rd), 32'h0000);
        csr_wr(CSR_CTRL, 16'h0005);
        csr_rd(CSR_CTRL, rd);
        chk("c_set_wins", 32'(rd), 32'h0004);

        // Abort during word 3 of 8: two words written, SRC write while busy dropped
        preload(15'h0300, 16'hBEEF);
        preload(15'h0301, 16'hCAFE);
        preload(15'h0302, 16'h5555);
        exp_rd_q.push_back(15'h0300); exp_rd_q.push_back(15'h0301); exp_rd_q.push_back(15'h0302);
        exp_wr_q.push_back('{15'h0400, 16'hBEEF});
        exp_wr_q.push_back('{15'h0401, 16'hCAFE});
        csr_wr(CSR_SRC, 16'h0300);
        csr_wr(CSR_DST, 16'h0400);
        csr_wr(CSR_LEN, 16'h0008);
        csr_wr(CSR_CTRL, 16'h0001);
        csr_wr(CSR_SRC, 16'h0555);
        repeat (5) tick();
        csr_wr(CSR_CTRL, 16'h0010);
        csr_rd(CSR_CTRL, rd);
        chk("d_abort_ctrl", 32'(rd), 32'h0000);
        repeat (8) tick();
        chk("d_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        chk("d_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        csr_rd(CSR_SRC, rd);
        chk("d_src_kept", 32'(rd), 32'h0300);
        chk("d_ram401", 32'(ram[15'h0401]), 32'hCAFE);

        // Reset asserted during the write of word 2
        exp_rd_q.push_back(15'h0100); exp_rd_q.push_back(15'h0101);
        exp_wr_q.push_back('{15'h0500, 16'hA0A0});
        csr_wr(CSR_SRC, 16'h0100);
        csr_wr(CSR_DST, 16'h0500);
        csr_wr(CSR_LEN, 16'h0004);
        csr_wr(CSR_CTRL, 16'h0009);
        repeat (5) tick();
        chk("e_in_wr", 32'(mem_write), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("e_rst_cs",    32'(mem_chipselect), 32'd0);
        chk("e_rst_write", 32'(mem_write),      32'd0);
        chk("e_rst_addr",  32'(mem_address),    32'd0);
        chk("e_rst_wdata", 32'(mem_writedata),  32'd0);
        chk("e_rst_irq",   32'(irq),            32'd0);
        csr_rd(CSR_CTRL, rd);
        chk("e_rst_ctrl", 32'(rd), 32'h0000);
        csr_rd(CSR_SRC, rd);
        chk("e_rst_src", 32'(rd), 32'h0000);
        csr_rd(CSR_LEN, rd);
        chk("e_rst_len", 32'(rd), 32'h0000);
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("e_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        chk("e_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        csr_rd(CSR_CTRL, rd);
        chk("e_idle_ctrl", 32'(rd), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
